// File: rtl/sdc_multilane_rx_if.sv
// Bundle of command, configuration, data and status signals for the multi-lane
// block receiver. The receiver uses the slave view; the controller uses master.
interface sdc_multilane_rx_if #(
  parameter int MAX_LANES = 4,
  parameter int BLKSIZE_W = 12,
  parameter int BLKCNT_W  = 16,
  parameter int TIMEOUT_W = 24
);
  logic [MAX_LANES-1:0] sdDat;
  logic [1:0]           laneMode;
  logic [BLKSIZE_W-1:0] blockSize;
  logic [BLKCNT_W-1:0]  blockCount;
  logic [TIMEOUT_W-1:0] timeoutValue;
  logic                 start;
  logic                 abort;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_last;
  logic                 blockDone;
  logic                 busy;
  logic                 crcError;
  logic                 frameError;
  logic                 timeout;
  logic                 cfgError;
  logic                 done;

  modport master (
    output sdDat, laneMode, blockSize, blockCount, timeoutValue, start, abort,
    input  out_data, out_valid, out_last, blockDone, busy,
           crcError, frameError, timeout, cfgError, done
  );

  modport slave (
    input  sdDat, laneMode, blockSize, blockCount, timeoutValue, start, abort,
    output out_data, out_valid, out_last, blockDone, busy,
           crcError, frameError, timeout, cfgError, done
  );
endinterface

// File: rtl/sdc_multilane_rx.sv
// SD-style multi-lane data block receiver: waits for a start bit, assembles
// bytes MSB first from 1, 4 or 8 lanes, checks one CRC16 per active lane,
// checks the end bit and repeats for the requested number of blocks.
module sdc_multilane_rx #(
  parameter int MAX_LANES = 4,
  parameter int BLKSIZE_W = 12,
  parameter int BLKCNT_W  = 16,
  parameter int TIMEOUT_W = 24
) (
  input logic clk,
  input logic rst,
  sdc_multilane_rx_if.slave bus
);

  localparam bit          HAS_4    = (MAX_LANES >= 4);
  localparam bit          HAS_8    = (MAX_LANES >= 8);
  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END_BIT, S_DONE
  } state_t;

  state_t               state_q;
  logic [1:0]           mode_q;
  logic [BLKSIZE_W-1:0] bsize_q;
  logic [BLKCNT_W-1:0]  bcount_q;
  logic [BLKCNT_W-1:0]  blk_cnt_q;
  logic [TIMEOUT_W-1:0] tmo_val_q;
  logic [TIMEOUT_W-1:0] tmo_cnt_q;
  logic [BLKSIZE_W-1:0] byte_cnt_q;
  logic [2:0]           bit_cnt_q;
  logic [3:0]           crc_cnt_q;
  logic [7:0]           shift_q;
  logic                 abort_pend_q;
  logic [MAX_LANES-1:0] crc_bad_q;
  logic [15:0]          crc_q [MAX_LANES];

  logic [7:0] out_data_q;
  logic       out_valid_q, out_last_q, block_done_q, busy_q, done_q;
  logic       crc_err_q, frame_err_q, timeout_q, cfg_err_q;

  logic [7:0]           dat_ext;
  logic [MAX_LANES-1:0] active;
  logic                 all_low, some_low, cfg_ok, bit_last, byte_last, blk_limit;
  logic [7:0]           byte_d;
  logic [15:0]          crc_d [MAX_LANES];
  logic [MAX_LANES-1:0] crc_mis;
  logic [TIMEOUT_W-1:0] tmo_inc;

  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] m);
    logic [7:0] full;
    case (m)
      2'd0:    full = 8'h01;
      2'd1:    full = 8'h0F;
      default: full = 8'hFF;
    endcase
    return full[MAX_LANES-1:0];
  endfunction

  // Present the bus as eight lanes; lanes that do not exist read as 0.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_ext
      if (gi < MAX_LANES) begin : g_real
        assign dat_ext[gi] = bus.sdDat[gi];
      end else begin : g_none
        assign dat_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // Per-lane serial CRC16 step for DATA and bit mismatch for the CRC phase.
  generate
    for (genvar gi = 0; gi < MAX_LANES; gi++) begin : g_crc
      logic fb;
      assign fb          = crc_q[gi][15] ^ bus.sdDat[gi];
      assign crc_d[gi]   = {crc_q[gi][14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      assign crc_mis[gi] = active[gi] & (crc_q[gi][15] != bus.sdDat[gi]);
    end
  endgenerate

  assign active    = lane_mask(mode_q);
  assign all_low   = ((bus.sdDat & active) == '0);
  assign some_low  = ((~bus.sdDat & active) != '0);
  assign tmo_inc   = tmo_cnt_q + TIMEOUT_W'(1);
  assign byte_last = (byte_cnt_q == bsize_q - BLKSIZE_W'(1));
  assign blk_limit = (bcount_q != '0) && (blk_cnt_q == bcount_q);
  assign cfg_ok    = (bus.blockSize != '0) &&
                     ((bus.laneMode == 2'd0) ||
                      (bus.laneMode == 2'd1 && HAS_4) ||
                      (bus.laneMode == 2'd2 && HAS_8));

  // Byte assembly: shift in the lane bits for this cycle and flag the final chunk.
  always_comb begin
    bit_last = 1'b1;
    byte_d   = dat_ext;
    case (mode_q)
      2'd0: begin
        bit_last = (bit_cnt_q == 3'd7);
        byte_d   = {shift_q[6:0], dat_ext[0]};
      end
      2'd1: begin
        bit_last = (bit_cnt_q == 3'd1);
        byte_d   = {shift_q[3:0], dat_ext[3:0]};
      end
      default: ;
    endcase
  end

  // Controller: state sequencing, counters, lane CRCs and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= 2'd0;
      bsize_q      <= '0;
      bcount_q     <= '0;
      blk_cnt_q    <= '0;
      tmo_val_q    <= '0;
      tmo_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      crc_cnt_q    <= '0;
      shift_q      <= '0;
      abort_pend_q <= 1'b0;
      crc_bad_q    <= '0;
      for (int i = 0; i < MAX_LANES; i++) crc_q[i] <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      block_done_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      crc_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      block_done_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (cfg_ok) begin
              mode_q       <= bus.laneMode;
              bsize_q      <= bus.blockSize;
              bcount_q     <= bus.blockCount;
              tmo_val_q    <= bus.timeoutValue;
              tmo_cnt_q    <= '0;
              blk_cnt_q    <= '0;
              abort_pend_q <= 1'b0;
              crc_err_q    <= 1'b0;
              frame_err_q  <= 1'b0;
              timeout_q    <= 1'b0;
              cfg_err_q    <= 1'b0;
              for (int i = 0; i < MAX_LANES; i++) crc_q[i] <= '0;
              busy_q       <= 1'b1;
              state_q      <= S_WAIT_START;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_WAIT_START: begin
          if (bus.abort) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (all_low) begin
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            state_q    <= S_DATA;
          end else if (some_low) begin
            // Lanes disagree on the start bit: the frame cannot be trusted.
            frame_err_q <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end else if (tmo_val_q != '0 && tmo_inc == tmo_val_q) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            tmo_cnt_q <= tmo_inc;
          end
        end
        S_DATA: begin
          if (bus.abort) abort_pend_q <= 1'b1;
          for (int i = 0; i < MAX_LANES; i++) crc_q[i] <= crc_d[i];
          shift_q <= byte_d;
          if (bit_last) begin
            bit_cnt_q   <= '0;
            out_data_q  <= byte_d;
            out_valid_q <= 1'b1;
            if (byte_last) begin
              out_last_q <= 1'b1;
              crc_cnt_q  <= '0;
              crc_bad_q  <= '0;
              state_q    <= S_CRC;
            end else begin
              byte_cnt_q <= byte_cnt_q + BLKSIZE_W'(1);
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        S_CRC: begin
          // Received CRC arrives MSB first: compare the top bit, then shift it out.
          if (bus.abort) abort_pend_q <= 1'b1;
          crc_bad_q <= crc_bad_q | crc_mis;
          for (int i = 0; i < MAX_LANES; i++) crc_q[i] <= {crc_q[i][14:0], 1'b0};
          if (crc_cnt_q == 4'd15) begin
            if ((crc_bad_q | crc_mis) != '0) crc_err_q <= 1'b1;
            block_done_q <= 1'b1;
            blk_cnt_q    <= blk_cnt_q + BLKCNT_W'(1);
            state_q      <= S_END_BIT;
          end else begin
            crc_cnt_q <= crc_cnt_q + 4'd1;
          end
        end
        S_END_BIT: begin
          if (some_low) frame_err_q <= 1'b1;
          if (bus.abort || abort_pend_q || some_low || blk_limit ||
              crc_err_q || frame_err_q || timeout_q || cfg_err_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmo_cnt_q <= '0;
            for (int i = 0; i < MAX_LANES; i++) crc_q[i] <= '0;
            state_q <= S_WAIT_START;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.blockDone  = block_done_q;
  assign bus.busy       = busy_q;
  assign bus.crcError   = crc_err_q;
  assign bus.frameError = frame_err_q;
  assign bus.timeout    = timeout_q;
  assign bus.cfgError   = cfg_err_q;
  assign bus.done       = done_q;

endmodule

// File: doc/sdc_multilane_rx.md
SDC_MULTILANE_RX -- requirements
Module: sdc_multilane_rx

Interface
REQ-001 SHALL have parameter MAX_LANES, 4, widest supported data bus (legal values 1, 4, 8).
REQ-002 SHALL have parameter BLKSIZE_W, 12, width of block size in bytes.
REQ-003 SHALL have parameter BLKCNT_W, 16, width of block count.
REQ-004 SHALL have parameter TIMEOUT_W, 24, width of start-bit timeout counter.
REQ-005 SHALL have port clk  input  1  receiver clock (SD card clock domain); one clock only.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port sdDat  input  MAX_LANES  sampled DAT lines.
REQ-008 SHALL have port laneMode  input  2  0=1-bit, 1=4-bit, 2=8-bit; values wider than MAX_LANES, and 3, are illegal.
REQ-009 SHALL have port blockSize  input  BLKSIZE_W  bytes per block.
REQ-010 SHALL have port blockCount  input  BLKCNT_W  blocks to receive; 0 = unlimited until abort.
REQ-011 SHALL have port timeoutValue  input  TIMEOUT_W  max cycles waiting for start bit; 0 = disabled.
REQ-012 SHALL have ports start, abort  input  1 each  single-cycle commands.
REQ-013 SHALL have ports out_data  output  8,  out_valid  output  1,  out_last  output  1 (last byte of a block).
REQ-014 SHALL have ports blockDone  output  1 (pulse),  busy  output  1,  crcError, frameError, timeout, cfgError  output  1 each (sticky), done  output  1 (pulse).

Function
REQ-015 SHALL implement states IDLE, WAIT_START, DATA, CRC, END_BIT, DONE.
REQ-016 IDLE: start with legal laneMode and blockSize!=0 SHALL latch config, clear sticky flags, enter WAIT_START; otherwise SHALL pulse-set cfgError and stay IDLE.
REQ-017 WAIT_START: all active lanes low SHALL enter DATA next cycle; some but not all active lanes low SHALL set frameError and go to DONE.
REQ-018 WAIT_START timeout counter SHALL clear on entry; reaching timeoutValue (nonzero) SHALL set timeout and go to DONE.
REQ-019 DATA: bits SHALL be MSB first; 1-bit: 8 cycles/byte on sdDat[0]; 4-bit: 2 cycles/byte, high nibble first on sdDat[3:0]; 8-bit: 1 cycle/byte on sdDat[7:0].
REQ-020 out_valid SHALL pulse for one cycle, the cycle after the edge sampling the byte's final bit; out_data stable while out_valid high; no backpressure.
REQ-021 out_last SHALL accompany the blockSize-th byte of each block.
REQ-022 Each active lane SHALL run an independent CRC16 (x^16+x^12+x^5+1, init 0) over its data bits.
REQ-023 CRC: 16 cycles compared per lane; any mismatch SHALL set crcError at CRC exit.
REQ-024 END_BIT: any active lane low SHALL set frameError; blockDone SHALL pulse this cycle.
REQ-025 After END_BIT: if any error flag set, or block counter equals nonzero blockCount, SHALL go to DONE; else WAIT_START.
REQ-026 Block counter SHALL be BLKCNT_W wide; with blockCount=0 it SHALL wrap without stopping.
REQ-027 abort in WAIT_START SHALL go to DONE immediately; in DATA/CRC/END_BIT SHALL complete the current block then go to DONE.
REQ-028 DONE SHALL pulse done one cycle and return to IDLE; start in DONE or any busy state SHALL be ignored.
REQ-029 busy SHALL be high in every state except IDLE.
REQ-030 Inactive lanes SHALL be ignored for start, end and CRC checks.

Reset
REQ-031 rst SHALL force IDLE, all outputs 0, counters and CRCs 0, regardless of state, including mid-block.

Verification
REQ-032 4-bit, blockSize=4, blockCount=1, bytes 0x12 0x34 0x56 0x78 with correct CRCs -> four out_valid pulses with those values, out_last on 0x78, blockDone, done, no errors.
REQ-033 Same frame with lane 2 CRC bit flipped -> crcError=1 at CRC exit, done, data still delivered.
REQ-034 1-bit, timeoutValue=10, lines held high -> timeout=1 after 10 cycles in WAIT_START, no out_valid.
REQ-035 8-bit, blockCount=0, three blocks of blockSize=2, abort during block 3 DATA -> 6 bytes, 3 blockDone, done after block 3 end bit.
REQ-036 laneMode=2 with MAX_LANES=4 -> cfgError=1, busy stays 0; rst asserted mid-DATA -> outputs 0 same cycle asynchronously.
